toggle_debounce: RTL and testbench

Upstream conditioning stage for the T flip-flop toggle input. Takes a raw, asynchronous, bouncing push-button/switch signal, synchronizes it to `clk`, and debounces it with a consecutive-sample counter. Produces a clean debounced level and a single-cycle toggle pulse `t`, which drives the `t` input of the downstream T flip-flop so that each physical press toggles `q` exactly once.

---
 rtl/toggle_debounce_pkg.sv | 14 +
 rtl/toggle_debounce_sync2.sv | 24 ++
 rtl/toggle_debounce.sv | 100 ++++++++++
 tb/tb_toggle_debounce.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/toggle_debounce_pkg.sv
// Shared types and constants for the button debounce stage.
// Optional build macro: TOGGLE_DEBOUNCE_BOTH_EDGES_EN.
package toggle_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } db_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/toggle_debounce_sync2.sv
// Two-flop synchronizer for the raw asynchronous button input.
// Both stages reset asynchronously to 0.
module sync2
    import toggle_debounce_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_debounce.sv
// Button debounce: synchronizer, qualification FSM and toggle pulse.
// Define TOGGLE_DEBOUNCE_BOTH_EDGES_EN to also pulse t on release.
module toggle_debounce
    import toggle_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic t,
    output logic level,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef TOGGLE_DEBOUNCE_BOTH_EDGES_EN
    localparam logic REL_PULSE = 1'b1;
`else
    localparam logic REL_PULSE = 1'b0;
`endif

    logic             s2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .q     (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            t     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            t <= 1'b0;
            unique case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        level <= 1'b1;
                        t     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        level <= 1'b0;
                        t     <= REL_PULSE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_debounce.sv
// Scoreboard bench for toggle_debounce with DEBOUNCE_CYCLES=4.
// Expected outputs are queued per edge and checked by a monitor.
module tb_toggle_debounce;

`ifdef TOGGLE_DEBOUNCE_BOTH_EDGES_EN
    localparam logic REL = 1'b1;
`else
    localparam logic REL = 1'b0;
`endif

    typedef struct {
        int   cyc;
        logic t;
        logic level;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic t, level, busy;
    logic q_tff;
    logic tff_clr;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic exp_q;
    exp_t expq[$];
    exp_t e;

    toggle_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .t     (t),
        .level (level),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream T flip-flop fed by the pulse.
    always @(posedge clk) begin
        if (tff_clr) q_tff <= 1'b0;
        else if (t) q_tff <= ~q_tff;
    end

    task automatic chk(string name, logic [2:0] act, logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic push(int c, logic et, logic el, logic eb);
        exp_t x;
        x.cyc = c;
        x.t = et;
        x.level = el;
        x.busy = eb;
        expq.push_back(x);
    endtask

    // Clean qualification: edges 1-2 sync, 3-5 wait, 6 commit.
    task automatic qual(logic to, logic pulse);
        int b;
        b = cyc;
        push(b + 1, 1'b0, ~to, 1'b0);
        push(b + 2, 1'b0, ~to, 1'b0);
        push(b + 3, 1'b0, ~to, 1'b1);
        push(b + 4, 1'b0, ~to, 1'b1);
        push(b + 5, 1'b0, ~to, 1'b1);
        push(b + 6, pulse, to, 1'b0);
        push(b + 7, 1'b0, to, 1'b0);
        push(b + 8, 1'b0, to, 1'b0);
        push(b + 9, 1'b0, to, 1'b0);
    endtask

    task automatic edges(int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            checks++;
            if (e.cyc != cyc || {t, level, busy} !== {e.t, e.level, e.busy}) begin
                errors++;
                $display("FAIL edge%0d t/level/busy: got %b%b%b at edge %0d expected %b%b%b",
                         e.cyc, t, level, busy, cyc, e.t, e.level, e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n = 1'b0;
        btn = 1'b0;
        tff_clr = 1'b1;
        exp_q = 1'b0;
        edges(3);
        chk("reset_outputs", {t, level, busy}, 3'b000);

        rst_n = 1'b1;
        b = cyc;
        push(b + 1, 1'b0, 1'b0, 1'b0);
        push(b + 2, 1'b0, 1'b0, 1'b0);
        push(b + 3, 1'b0, 1'b0, 1'b0);
        edges(3);

        btn = 1'b1;
        qual(1'b1, 1'b1);
        edges(9);

        rst_n = 1'b0;
        #1;
        chk("async_reset", {t, level, busy}, 3'b000);
        edges(2);
        chk("held_reset", {t, level, busy}, 3'b000);
        rst_n = 1'b1;
        qual(1'b1, 1'b1);
        edges(9);

        btn = 1'b0;
        qual(1'b0, REL);
        edges(9);

        b = cyc;
        btn = 1'b1;
        push(b + 1, 1'b0, 1'b0, 1'b0);
        push(b + 2, 1'b0, 1'b0, 1'b0);
        push(b + 3, 1'b0, 1'b0, 1'b1);
        push(b + 4, 1'b0, 1'b0, 1'b1);
        push(b + 5, 1'b0, 1'b0, 1'b0);
        push(b + 6, 1'b0, 1'b0, 1'b0);
        edges(2);
        btn = 1'b0;
        edges(4);

        b = cyc;
        btn = 1'b1;
        push(b + 1, 1'b0, 1'b0, 1'b0);
        push(b + 2, 1'b0, 1'b0, 1'b0);
        push(b + 3, 1'b0, 1'b0, 1'b1);
        push(b + 4, 1'b0, 1'b0, 1'b1);
        push(b + 5, 1'b0, 1'b0, 1'b1);
        push(b + 6, 1'b0, 1'b0, 1'b0);
        push(b + 7, 1'b0, 1'b0, 1'b1);
        push(b + 8, 1'b0, 1'b0, 1'b1);
        push(b + 9, 1'b0, 1'b0, 1'b1);
        push(b + 10, 1'b1, 1'b1, 1'b0);
        push(b + 11, 1'b0, 1'b1, 1'b0);
        push(b + 12, 1'b0, 1'b1, 1'b0);
        edges(3);
        btn = 1'b0;
        edges(1);
        btn = 1'b1;
        edges(8);

        btn = 1'b0;
        qual(1'b0, REL);
        edges(9);

        tff_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            qual(1'b1, 1'b1);
            edges(9);
            exp_q = ~exp_q;
            chk($sformatf("tff_press%0d", i), {2'b00, q_tff}, {2'b00, exp_q});
            btn = 1'b0;
            qual(1'b0, REL);
            edges(9);
            exp_q = exp_q ^ REL;
            chk($sformatf("tff_release%0d", i), {2'b00, q_tff}, {2'b00, exp_q});
        end

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
